// File: rtl/pdp11_run_ctl.sv
// Run controller for a PDP-11 core: sequences core reset, counts cycles and
// instructions, emits a fetch trace and ends the run on halt, breakpoint or timeout.
module pdp11_run_ctl #(
  parameter int unsigned IST_W       = 5,
  parameter int unsigned FETCH_STATE = 1,
  parameter int unsigned HALT_STATE  = 0,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned HALT_HOLD   = 1,
  parameter int unsigned CYC_W       = 32,
  parameter int unsigned MAX_CYCLES  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IST_W-1:0] istate,
  input  logic [15:0]      pc,
  input  logic [15:0]      psw,
  input  logic             bp_en,
  input  logic [15:0]      bp_addr,
  output logic             cpu_reset_n,
  output logic             running,
  output logic             done,
  output logic [1:0]       status,
  output logic [CYC_W-1:0] cycle_count,
  output logic [CYC_W-1:0] instr_count,
  output logic             trace_valid,
  output logic [15:0]      trace_pc,
  output logic [15:0]      trace_psw
);

  localparam int unsigned RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned HALT_W = $clog2(HALT_HOLD + 1);

  localparam logic [1:0] STAT_NONE    = 2'd0;
  localparam logic [1:0] STAT_HALTED  = 2'd1;
  localparam logic [1:0] STAT_BREAK   = 2'd2;
  localparam logic [1:0] STAT_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [RST_W-1:0]  rst_cnt, rst_cnt_nxt;
  logic [HALT_W-1:0] halt_cnt, halt_cnt_nxt;
  logic              prev_fetch, prev_fetch_nxt;
  logic              cpu_reset_n_nxt, running_nxt, done_nxt, trace_valid_nxt;
  logic [1:0]        status_nxt;
  logic [CYC_W-1:0]  cycle_count_nxt, instr_count_nxt;
  logic [15:0]       trace_pc_nxt, trace_psw_nxt;

  // Per-edge observations of the core, only acted on in RUN
  logic              is_fetch, is_halt, fetch_hit;
  logic              halt_ev, bp_ev, to_ev;
  logic [CYC_W-1:0]  cyc_inc, instr_inc;
  logic [HALT_W-1:0] halt_inc;

  always_comb begin
    is_fetch  = (istate == IST_W'(FETCH_STATE));
    is_halt   = (istate == IST_W'(HALT_STATE));
    fetch_hit = is_fetch && !prev_fetch;
    cyc_inc   = (&cycle_count) ? cycle_count : cycle_count + CYC_W'(1);
    instr_inc = (&instr_count) ? instr_count : instr_count + CYC_W'(1);
    if (!is_halt)
      halt_inc = '0;
    else if (halt_cnt == HALT_W'(HALT_HOLD))
      halt_inc = halt_cnt;
    else
      halt_inc = halt_cnt + HALT_W'(1);
    halt_ev = is_halt && (halt_inc == HALT_W'(HALT_HOLD));
    bp_ev   = fetch_hit && bp_en && (pc == bp_addr);
    to_ev   = (MAX_CYCLES != 0) && (cyc_inc == CYC_W'(MAX_CYCLES));
  end

  // Next-state and output logic
  always_comb begin
    state_nxt       = state;
    rst_cnt_nxt     = rst_cnt;
    halt_cnt_nxt    = '0;
    prev_fetch_nxt  = 1'b0;
    cpu_reset_n_nxt = cpu_reset_n;
    running_nxt     = running;
    done_nxt        = done;
    status_nxt      = status;
    cycle_count_nxt = cycle_count;
    instr_count_nxt = instr_count;
    trace_valid_nxt = 1'b0;
    trace_pc_nxt    = trace_pc;
    trace_psw_nxt   = trace_psw;

    case (state)
      ST_RESET: begin
        if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
          state_nxt       = ST_RUN;
          cpu_reset_n_nxt = 1'b1;
          running_nxt     = 1'b1;
        end else begin
          rst_cnt_nxt = rst_cnt + RST_W'(1);
        end
      end
      ST_RUN: begin
        cycle_count_nxt = cyc_inc;
        prev_fetch_nxt  = is_fetch;
        halt_cnt_nxt    = halt_inc;
        if (fetch_hit) begin
          instr_count_nxt = instr_inc;
          trace_valid_nxt = 1'b1;
          trace_pc_nxt    = pc;
          trace_psw_nxt   = psw;
        end
        if (halt_ev || bp_ev || to_ev) begin
          state_nxt   = ST_DONE;
          running_nxt = 1'b0;
          done_nxt    = 1'b1;
          if (halt_ev)
            status_nxt = STAT_HALTED;
          else if (bp_ev)
            status_nxt = STAT_BREAK;
          else
            status_nxt = STAT_TIMEOUT;
        end
      end
      ST_DONE: ;
      default: state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_RESET;
      rst_cnt     <= '0;
      halt_cnt    <= '0;
      prev_fetch  <= 1'b0;
      cpu_reset_n <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      status      <= STAT_NONE;
      cycle_count <= '0;
      instr_count <= '0;
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_psw   <= '0;
    end else begin
      state       <= state_nxt;
      rst_cnt     <= rst_cnt_nxt;
      halt_cnt    <= halt_cnt_nxt;
      prev_fetch  <= prev_fetch_nxt;
      cpu_reset_n <= cpu_reset_n_nxt;
      running     <= running_nxt;
      done        <= done_nxt;
      status      <= status_nxt;
      cycle_count <= cycle_count_nxt;
      instr_count <= instr_count_nxt;
      trace_valid <= trace_valid_nxt;
      trace_pc    <= trace_pc_nxt;
      trace_psw   <= trace_psw_nxt;
    end
  end

endmodule

// File: tb/tb_pdp11_run_ctl.sv
// Directed bench for pdp11_run_ctl: three instances with different halt and
// timeout parameters share one stimulus stream; each scenario checks one of them.
module tb_pdp11_run_ctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  istate;
  logic [15:0] pc, psw, bp_addr;
  logic        bp_en;

  logic        a_crn, a_run, a_done, a_tv;
  logic [1:0]  a_stat;
  logic [31:0] a_cyc, a_ins;
  logic [15:0] a_tpc, a_tpsw;
  logic        b_crn, b_run, b_done, b_tv;
  logic [1:0]  b_stat;
  logic [31:0] b_cyc, b_ins;
  logic [15:0] b_tpc, b_tpsw;
  logic        c_crn, c_run, c_done, c_tv;
  logic [1:0]  c_stat;
  logic [31:0] c_cyc, c_ins;
  logic [15:0] c_tpc, c_tpsw;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // A: halt after 4 cycles, no timeout
  pdp11_run_ctl #(.HALT_HOLD(4), .MAX_CYCLES(0)) u_a (
    .clk(clk), .reset_n(reset_n), .istate(istate), .pc(pc), .psw(psw),
    .bp_en(bp_en), .bp_addr(bp_addr), .cpu_reset_n(a_crn), .running(a_run),
    .done(a_done), .status(a_stat), .cycle_count(a_cyc), .instr_count(a_ins),
    .trace_valid(a_tv), .trace_pc(a_tpc), .trace_psw(a_tpsw));

  // B: timeout at 10
  pdp11_run_ctl #(.HALT_HOLD(1), .MAX_CYCLES(10)) u_b (
    .clk(clk), .reset_n(reset_n), .istate(istate), .pc(pc), .psw(psw),
    .bp_en(bp_en), .bp_addr(bp_addr), .cpu_reset_n(b_crn), .running(b_run),
    .done(b_done), .status(b_stat), .cycle_count(b_cyc), .instr_count(b_ins),
    .trace_valid(b_tv), .trace_pc(b_tpc), .trace_psw(b_tpsw));

  // C: timeout at 8, halt on first halt cycle
  pdp11_run_ctl #(.HALT_HOLD(1), .MAX_CYCLES(8)) u_c (
    .clk(clk), .reset_n(reset_n), .istate(istate), .pc(pc), .psw(psw),
    .bp_en(bp_en), .bp_addr(bp_addr), .cpu_reset_n(c_crn), .running(c_run),
    .done(c_done), .status(c_stat), .cycle_count(c_cyc), .instr_count(c_ins),
    .trace_valid(c_tv), .trace_pc(c_tpc), .trace_psw(c_tpsw));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset all instances and release into RUN with neutral istate
  task automatic reset_to_run();
    reset_n = 1'b0;
    istate  = 5'd2;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    tick();
  endtask

  logic [4:0]  seq_ist [6];
  logic [15:0] seq_pc  [6];
  logic        seq_tv  [6];
  int          pulses;

  initial begin
    reset_n = 1'b0; istate = 5'd2; pc = '0; psw = '0; bp_en = 1'b0; bp_addr = '0;

    // 1: reset state and release sequencing
    repeat (3) tick();
    check("rst_crn", 32'(a_crn), 32'd0);
    check("rst_run", 32'(a_run), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_stat", 32'(a_stat), 32'd0);
    check("rst_cyc", a_cyc, 32'd0);
    check("rst_tpc", 32'(a_tpc), 32'd0);
    reset_n = 1'b1;
    tick();
    check("rel1_crn", 32'(a_crn), 32'd0);
    check("rel1_run", 32'(a_run), 32'd0);
    tick();
    check("rel2_crn", 32'(a_crn), 32'd1);
    check("rel2_run", 32'(a_run), 32'd1);
    check("rel2_cyc", a_cyc, 32'd0);

    // 2: fetch edge detection and trace
    seq_ist = '{5'd1, 5'd1, 5'd2, 5'd3, 5'd1, 5'd4};
    seq_pc  = '{16'o1000, 16'o1000, 16'o1001, 16'o1001, 16'o1002, 16'o1002};
    seq_tv  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      istate = seq_ist[i];
      pc     = seq_pc[i];
      psw    = 16'(16'h0100 + i);
      tick();
      check($sformatf("tv_%0d", i), 32'(a_tv), 32'(seq_tv[i]));
      if (a_tv) pulses++;
      if (i == 0) begin
        check("tpc_0", 32'(a_tpc), 32'o1000);
        check("tpsw_0", 32'(a_tpsw), 32'h0100);
      end
      if (i == 4) check("tpc_4", 32'(a_tpc), 32'o1002);
    end
    check("tv_pulses", 32'(pulses), 32'd2);
    check("ins_2", a_ins, 32'd2);
    check("cyc_6", a_cyc, 32'd6);
    check("tpc_hold", 32'(a_tpc), 32'o1002);

    // 3: halt needs 4 consecutive cycles
    istate = 5'd0;
    repeat (3) tick();
    istate = 5'd2;
    tick();
    check("halt_short", 32'(a_done), 32'd0);
    istate = 5'd0;
    repeat (3) tick();
    check("halt_3", 32'(a_done), 32'd0);
    tick();
    check("halt_done", 32'(a_done), 32'd1);
    check("halt_stat", 32'(a_stat), 32'd1);
    check("halt_run", 32'(a_run), 32'd0);
    check("halt_cyc", a_cyc, 32'd14);
    istate = 5'd1;
    repeat (3) tick();
    check("done_ins", a_ins, 32'd2);
    check("done_tv", 32'(a_tv), 32'd0);
    check("done_cyc", a_cyc, 32'd14);
    check("done_crn", 32'(a_crn), 32'd1);

    // 4: timeout at 10 and freeze
    reset_to_run();
    check("to_start", b_cyc, 32'd0);
    istate = 5'd2;
    repeat (9) tick();
    check("to_9", 32'(b_done), 32'd0);
    tick();
    check("to_done", 32'(b_done), 32'd1);
    check("to_stat", 32'(b_stat), 32'd3);
    check("to_cyc", b_cyc, 32'd10);
    repeat (5) tick();
    check("to_freeze", b_cyc, 32'd10);
    check("to_ins", b_ins, 32'd0);

    // 5: breakpoint
    reset_to_run();
    bp_en = 1'b1; bp_addr = 16'o1000; psw = 16'h00e0;
    istate = 5'd1; pc = 16'o776;
    tick();
    check("bp_miss", 32'(a_done), 32'd0);
    istate = 5'd2;
    tick();
    istate = 5'd1; pc = 16'o1000;
    tick();
    check("bp_done", 32'(a_done), 32'd1);
    check("bp_stat", 32'(a_stat), 32'd2);
    check("bp_tv", 32'(a_tv), 32'd1);
    check("bp_tpc", 32'(a_tpc), 32'o1000);
    check("bp_ins", a_ins, 32'd2);
    tick();
    check("bp_tv_off", 32'(a_tv), 32'd0);
    bp_en = 1'b0;

    // 6: halt beats timeout on the same edge, then reset from DONE
    reset_to_run();
    istate = 5'd2;
    repeat (7) tick();
    check("pri_7", 32'(c_done), 32'd0);
    istate = 5'd0;
    tick();
    check("pri_done", 32'(c_done), 32'd1);
    check("pri_stat", 32'(c_stat), 32'd1);
    check("pri_cyc", c_cyc, 32'd8);
    reset_n = 1'b0;
    tick();
    check("rd_crn", 32'(c_crn), 32'd0);
    check("rd_done", 32'(c_done), 32'd0);
    check("rd_run", 32'(c_run), 32'd0);
    check("rd_stat", 32'(c_stat), 32'd0);
    check("rd_cyc", c_cyc, 32'd0);
    check("rd_ins", c_ins, 32'd0);
    check("rd_tv", 32'(c_tv), 32'd0);
    check("rd_tpc", 32'(c_tpc), 32'd0);
    check("rd_tpsw", 32'(c_tpsw), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
